// File: rtl/mem_wb_stage.sv
// mem_wb_stage: back end of the pipeline behind the execute stage.
//
// Holds the EX/MEM and MEM/WB pipeline registers, drives the data SRAM port from EX/MEM,
// aligns and extends load data in WB, and returns EX/MEM and WB values to the execute-stage
// forwarding muxes. It flags misaligned data addresses and suppresses the register write of
// faulting or overflowing instructions.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   ex_valid              execute stage holds a real instruction
//   ex_out                execute result; also the memory address
//   ex_rt_data            forwarded Rt value (store data)
//   ex_rd                 destination register
//   ex_regwrite/memread/memwrite/mem_sign   control bits (mem_sign=1: sign-extending load)
//   ex_mem_size           00 byte, 01 half, 10/11 word
//   ex_overflow           arithmetic overflow, kills the register write
//   ex_result_notok       execute result unusable, inserts a bubble
//   stall                 freezes both pipeline registers
//   flush                 turns the EX/MEM load into a bubble (wins over stall)
//   data_sram_*           SRAM port; rdata is valid one cycle after en
//   EX_MEM_*              EX/MEM result and control for forwarding / hazard detection
//   WBvalue, MEM_WB_*     write-back data, destination and write enable
//   adel, ades            load / store address error, combinational from EX/MEM
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_out,
  input  logic [31:0] ex_rt_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic        ex_mem_sign,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_overflow,
  input  logic        ex_result_notok,
  input  logic        stall,
  input  logic        flush,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] EX_MEM_aluout,
  output logic [4:0]  EX_MEM_Rd,
  output logic        EX_MEM_RegWrite,
  output logic        EX_MEM_MemRead,
  output logic [31:0] WBvalue,
  output logic [4:0]  MEM_WB_Rd,
  output logic        MEM_WB_RegWrite,
  output logic        adel,
  output logic        ades
);

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;

  // ---------------------------------------------------------------------------------------------
  // EX/MEM register
  // ---------------------------------------------------------------------------------------------
  logic        r_em_valid;
  logic [31:0] r_em_result;
  logic [31:0] r_em_rt;
  logic [4:0]  r_em_rd;
  logic        r_em_regwrite;
  logic        r_em_memread;
  logic        r_em_memwrite;
  logic        r_em_sign;
  logic [1:0]  r_em_size;

  // A bubble clears every field, so a dead slot never leaks stale data onto the SRAM port
  // or the forwarding path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_em_valid    <= 1'b0;
      r_em_result   <= '0;
      r_em_rt       <= '0;
      r_em_rd       <= '0;
      r_em_regwrite <= 1'b0;
      r_em_memread  <= 1'b0;
      r_em_memwrite <= 1'b0;
      r_em_sign     <= 1'b0;
      r_em_size     <= '0;
    end else if (flush || (!stall && (ex_result_notok || !ex_valid))) begin
      r_em_valid    <= 1'b0;
      r_em_result   <= '0;
      r_em_rt       <= '0;
      r_em_rd       <= '0;
      r_em_regwrite <= 1'b0;
      r_em_memread  <= 1'b0;
      r_em_memwrite <= 1'b0;
      r_em_sign     <= 1'b0;
      r_em_size     <= '0;
    end else if (!stall) begin
      r_em_valid    <= 1'b1;
      r_em_result   <= ex_out;
      r_em_rt       <= ex_rt_data;
      r_em_rd       <= ex_rd;
      r_em_regwrite <= ex_regwrite & ~ex_overflow;
      r_em_memread  <= ex_memread;
      r_em_memwrite <= ex_memwrite;
      r_em_sign     <= ex_mem_sign;
      r_em_size     <= ex_mem_size;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Address check and SRAM port
  // ---------------------------------------------------------------------------------------------
  logic w_misaligned;
  logic w_adel;
  logic w_ades;
  logic w_en;

  always_comb begin
    w_misaligned = 1'b0;
    unique case (r_em_size)
      SizeByte: w_misaligned = 1'b0;
      SizeHalf: w_misaligned = r_em_result[0];
      default:  w_misaligned = |r_em_result[1:0];
    endcase
  end

  assign w_adel = r_em_valid & r_em_memread  & w_misaligned;
  assign w_ades = r_em_valid & r_em_memwrite & w_misaligned;
  assign w_en   = r_em_valid & (r_em_memread | r_em_memwrite) & ~w_adel & ~w_ades & ~stall;

  logic [3:0]  w_wen;
  logic [31:0] w_wdata;

  always_comb begin
    w_wen = 4'b0000;
    if (w_en && r_em_memwrite) begin
      unique case (r_em_size)
        SizeByte: w_wen = 4'b0001 << r_em_result[1:0];
        SizeHalf: w_wen = 4'b0011 << {r_em_result[1], 1'b0};
        default:  w_wen = 4'b1111;
      endcase
    end
  end

  // Store data is replicated across lanes; the byte mask picks the lane that lands.
  always_comb begin
    w_wdata = r_em_rt;
    unique case (r_em_size)
      SizeByte: w_wdata = {4{r_em_rt[7:0]}};
      SizeHalf: w_wdata = {2{r_em_rt[15:0]}};
      default:  w_wdata = r_em_rt;
    endcase
  end

  assign data_sram_en    = w_en;
  assign data_sram_wen   = w_wen;
  assign data_sram_addr  = r_em_result;
  assign data_sram_wdata = w_wdata;
  assign adel            = w_adel;
  assign ades            = w_ades;

  assign EX_MEM_aluout   = r_em_result;
  assign EX_MEM_Rd       = r_em_rd;
  assign EX_MEM_RegWrite = r_em_regwrite;
  assign EX_MEM_MemRead  = r_em_memread;

  // ---------------------------------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------------------------------
  logic [31:0] r_wb_result;
  logic [4:0]  r_wb_rd;
  logic        r_wb_regwrite;
  logic        r_wb_memread;
  logic [1:0]  r_wb_size;
  logic        r_wb_sign;
  logic [1:0]  r_wb_off;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_result   <= '0;
      r_wb_rd       <= '0;
      r_wb_regwrite <= 1'b0;
      r_wb_memread  <= 1'b0;
      r_wb_size     <= '0;
      r_wb_sign     <= 1'b0;
      r_wb_off      <= '0;
    end else if (!stall) begin
      if (!r_em_valid) begin
        r_wb_result   <= '0;
        r_wb_rd       <= '0;
        r_wb_regwrite <= 1'b0;
        r_wb_memread  <= 1'b0;
        r_wb_size     <= '0;
        r_wb_sign     <= 1'b0;
        r_wb_off      <= '0;
      end else begin
        r_wb_result   <= r_em_result;
        r_wb_rd       <= r_em_rd;
        r_wb_regwrite <= r_em_regwrite & ~w_adel;
        r_wb_memread  <= r_em_memread;
        r_wb_size     <= r_em_size;
        r_wb_sign     <= r_em_sign;
        r_wb_off      <= r_em_result[1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read-data hold: the SRAM only drives the load word for one cycle, so a stall while a load
  // sits in WB would otherwise lose it.
  // ---------------------------------------------------------------------------------------------
  logic        r_hold_valid;
  logic [31:0] r_hold_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (stall) begin
      if (r_wb_memread && !r_hold_valid) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= data_sram_rdata;
      end
    end else begin
      r_hold_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------------------------
  logic [31:0] w_src;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  always_comb begin
    w_src  = r_hold_valid ? r_hold_data : data_sram_rdata;
    w_byte = w_src[7:0];
    unique case (r_wb_off)
      2'd0: w_byte = w_src[7:0];
      2'd1: w_byte = w_src[15:8];
      2'd2: w_byte = w_src[23:16];
      2'd3: w_byte = w_src[31:24];
    endcase
    w_half = r_wb_off[1] ? w_src[31:16] : w_src[15:0];
    w_load = w_src;
    unique case (r_wb_size)
      SizeByte: w_load = {{24{r_wb_sign & w_byte[7]}}, w_byte};
      SizeHalf: w_load = {{16{r_wb_sign & w_half[15]}}, w_half};
      default:  w_load = w_src;
    endcase
  end

  assign WBvalue         = r_wb_memread ? w_load : r_wb_result;
  assign MEM_WB_Rd       = r_wb_rd;
  assign MEM_WB_RegWrite = r_wb_regwrite;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model with a golden memory.
module tb_mem_wb_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        sign;
    logic [1:0]  size;
    logic        ovf;
    logic        notok;
  } ex_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        sign;
    logic        err;
    logic [1:0]  size;
    logic [1:0]  off;
    logic [31:0] word;
  } wb_t;

  logic clk;
  logic rst;
  ex_t  cur;
  logic stall_i;
  logic flush_i;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [31:0] EX_MEM_aluout;
  logic [4:0]  EX_MEM_Rd;
  logic        EX_MEM_RegWrite;
  logic        EX_MEM_MemRead;
  logic [31:0] WBvalue;
  logic [4:0]  MEM_WB_Rd;
  logic        MEM_WB_RegWrite;
  logic        adel;
  logic        ades;

  mem_wb_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (cur.valid),
    .ex_out          (cur.result),
    .ex_rt_data      (cur.rt),
    .ex_rd           (cur.rd),
    .ex_regwrite     (cur.rw),
    .ex_memread      (cur.mr),
    .ex_memwrite     (cur.mw),
    .ex_mem_sign     (cur.sign),
    .ex_mem_size     (cur.size),
    .ex_overflow     (cur.ovf),
    .ex_result_notok (cur.notok),
    .stall           (stall_i),
    .flush           (flush_i),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .EX_MEM_aluout   (EX_MEM_aluout),
    .EX_MEM_Rd       (EX_MEM_Rd),
    .EX_MEM_RegWrite (EX_MEM_RegWrite),
    .EX_MEM_MemRead  (EX_MEM_MemRead),
    .WBvalue         (WBvalue),
    .MEM_WB_Rd       (MEM_WB_Rd),
    .MEM_WB_RegWrite (MEM_WB_RegWrite),
    .adel            (adel),
    .ades            (ades)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM: 64 words at 0x100..0x1FF; rdata is garbage whenever the array was not read.
  logic [31:0] smem [64];
  logic [31:0] gmem [64];

  always @(posedge clk) begin
    if (data_sram_en && data_sram_wen == 4'b0000) begin
      data_sram_rdata <= smem[data_sram_addr[7:2]];
    end else begin
      data_sram_rdata <= $urandom;
    end
    if (data_sram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) smem[data_sram_addr[7:2]][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Reference model: access rules expressed as byte counts and lane ranges
  // ---------------------------------------------------------------------------------------------
  ex_t m_em;
  wb_t m_wb;

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic misal(input logic [1:0] s, input logic [1:0] a);
    return (int'(a) % nbytes(s)) != 0;
  endfunction

  function automatic logic [31:0] lane_data(input logic [31:0] rt, input logic [1:0] s);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = rt[8*(i % nbytes(s)) +: 8];
    return d;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] s, input logic [1:0] a);
    logic [3:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) if (i >= int'(a) && i < int'(a) + nbytes(s)) w[i] = 1'b1;
    return w;
  endfunction

  function automatic logic [31:0] fmt(input logic [31:0] word, input logic [1:0] s,
                                      input logic [1:0] off, input logic sgn);
    logic [31:0] v;
    int n;
    n = nbytes(s);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*((int'(off) + i) % 4) +: 8];
    if (sgn && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic em_adel();
    return m_em.valid && m_em.mr && misal(m_em.size, m_em.result[1:0]);
  endfunction

  function automatic logic em_ades();
    return m_em.valid && m_em.mw && misal(m_em.size, m_em.result[1:0]);
  endfunction

  task automatic model_step();
    logic [5:0]  idx;
    logic [3:0]  msk;
    logic [31:0] d;
    idx = m_em.result[7:2];
    if (!stall_i) begin
      if (!m_em.valid) begin
        m_wb = '0;
      end else begin
        m_wb.result = m_em.result;
        m_wb.rd     = m_em.rd;
        m_wb.rw     = m_em.rw && !em_adel();
        m_wb.mr     = m_em.mr;
        m_wb.sign   = m_em.sign;
        m_wb.err    = em_adel();
        m_wb.size   = m_em.size;
        m_wb.off    = m_em.result[1:0];
        m_wb.word   = gmem[idx];
      end
      if (m_em.valid && m_em.mw && !em_ades()) begin
        msk = lane_mask(m_em.size, m_em.result[1:0]);
        d   = lane_data(m_em.rt, m_em.size);
        for (int i = 0; i < 4; i++) if (msk[i]) gmem[idx][8*i +: 8] = d[8*i +: 8];
      end
    end
    if (flush_i) begin
      m_em = '0;
    end else if (!stall_i) begin
      if (cur.notok || !cur.valid) begin
        m_em = '0;
      end else begin
        m_em     = cur;
        m_em.rw  = cur.rw && !cur.ovf;
        m_em.ovf = 1'b0;
        m_em.notok = 1'b0;
      end
    end
  endtask

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_on) begin
      logic exp_en;
      exp_en = m_em.valid && (m_em.mr || m_em.mw) && !em_adel() && !em_ades() && !stall_i;
      chk("adel", {31'd0, adel}, {31'd0, em_adel()});
      chk("ades", {31'd0, ades}, {31'd0, em_ades()});
      chk("en", {31'd0, data_sram_en}, {31'd0, exp_en});
      chk("wen", {28'd0, data_sram_wen},
          {28'd0, (exp_en && m_em.mw) ? lane_mask(m_em.size, m_em.result[1:0]) : 4'b0000});
      chk("addr", data_sram_addr, m_em.result);
      chk("wdata", data_sram_wdata, lane_data(m_em.rt, m_em.size));
      chk("em_rd", {27'd0, EX_MEM_Rd}, {27'd0, m_em.rd});
      chk("em_rw", {31'd0, EX_MEM_RegWrite}, {31'd0, m_em.rw});
      chk("em_mr", {31'd0, EX_MEM_MemRead}, {31'd0, m_em.mr});
      chk("wb_rd", {27'd0, MEM_WB_Rd}, {27'd0, m_wb.rd});
      chk("wb_rw", {31'd0, MEM_WB_RegWrite}, {31'd0, m_wb.rw});
      if (!(m_wb.mr && m_wb.err)) begin
        chk("wbvalue", WBvalue,
            m_wb.mr ? fmt(m_wb.word, m_wb.size, m_wb.off, m_wb.sign) : m_wb.result);
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------------------------
  task automatic set_in(input ex_t e, input logic st, input logic fl);
    cur     = e;
    stall_i = st;
    flush_i = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step(input ex_t e, input logic st, input logic fl);
    set_in(e, st, fl);
    tick();
  endtask

  function automatic ex_t alu(input logic [31:0] r, input logic [4:0] rd, input logic ovf,
                              input logic notok);
    ex_t e;
    e = '0;
    e.valid = 1'b1; e.result = r; e.rd = rd; e.rw = 1'b1; e.ovf = ovf; e.notok = notok;
    return e;
  endfunction

  function automatic ex_t ld(input logic [31:0] a, input logic [4:0] rd, input logic [1:0] s,
                             input logic sgn);
    ex_t e;
    e = '0;
    e.valid = 1'b1; e.result = a; e.rd = rd; e.rw = 1'b1; e.mr = 1'b1; e.size = s;
    e.sign = sgn;
    return e;
  endfunction

  function automatic ex_t st(input logic [31:0] a, input logic [31:0] rt, input logic [1:0] s);
    ex_t e;
    e = '0;
    e.valid = 1'b1; e.result = a; e.rt = rt; e.mw = 1'b1; e.size = s;
    return e;
  endfunction

  function automatic ex_t rnd_ex();
    ex_t e;
    int op;
    logic [1:0] off;
    e = '0;
    op      = int'($urandom_range(0, 2));
    e.valid = ($urandom_range(0, 9) != 0);
    e.result = $urandom;
    e.rt    = $urandom;
    e.rd    = 5'($urandom);
    e.size  = 2'($urandom);
    e.sign  = 1'($urandom);
    e.ovf   = ($urandom_range(0, 9) == 0);
    e.notok = ($urandom_range(0, 9) == 0);
    if (op == 0) e.rw = 1'b1;
    if (op == 1) begin e.mr = 1'b1; e.rw = 1'b1; end
    if (op == 2) e.mw = 1'b1;
    if (op != 0) begin
      off = 2'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        if (e.size == 2'b01) off[0] = 1'b0;
        else if (e.size[1]) off = 2'b00;
      end
      e.result = {23'd0, 1'b1, 6'($urandom), off};
    end
    return e;
  endfunction

  task automatic load_chk(input string name, input logic [31:0] a, input logic [1:0] s,
                          input logic sgn, input logic [31:0] exp);
    step(ld(a, 5'd6, s, sgn), 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    #1;
    chk(name, WBvalue, exp);
    chk({name, "_rw"}, {31'd0, MEM_WB_RegWrite}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    set_in('0, 1'b0, 1'b0);
    m_em = '0;
    m_wb = '0;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = (i == 32) ? 32'h8070_F0A5 : $urandom;
      smem[i] <= v;
      gmem[i] = v;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", {31'd0, data_sram_en}, 32'd0);
    chk("rst_addr", data_sram_addr, 32'd0);
    chk("rst_wbvalue", WBvalue, 32'd0);
    chk("rst_em_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    rst    = 1'b1;
    chk_on = 1'b1;

    // Word store then load of the same word.
    step(st(32'h100, 32'hDEAD_BEEF, 2'b10), 1'b0, 1'b0);
    set_in('0, 1'b0, 1'b0);
    #1;
    chk("sw_wen", {28'd0, data_sram_wen}, 32'hF);
    chk("sw_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    tick();
    step(ld(32'h100, 5'd5, 2'b10, 1'b0), 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    #1;
    chk("lw_value", WBvalue, 32'hDEAD_BEEF);
    chk("lw_rd", {27'd0, MEM_WB_Rd}, 32'd5);
    chk("lw_rw", {31'd0, MEM_WB_RegWrite}, 32'd1);

    // Sub-word loads from 0x8070F0A5.
    load_chk("lb0", 32'h180, 2'b00, 1'b1, 32'hFFFF_FFA5);
    load_chk("lbu1", 32'h181, 2'b00, 1'b0, 32'h0000_00F0);
    load_chk("lh2", 32'h182, 2'b01, 1'b1, 32'hFFFF_8070);

    // Sub-word stores.
    step(st(32'h1C3, 32'h12, 2'b00), 1'b0, 1'b0);
    set_in('0, 1'b0, 1'b0);
    #1;
    chk("sb_wen", {28'd0, data_sram_wen}, 32'b1000);
    chk("sb_wdata", data_sram_wdata, 32'h1212_1212);
    tick();
    step(st(32'h1C2, 32'h3456, 2'b01), 1'b0, 1'b0);
    set_in('0, 1'b0, 1'b0);
    #1;
    chk("sh_wen", {28'd0, data_sram_wen}, 32'b1100);
    chk("sh_wdata", data_sram_wdata, 32'h3456_3456);
    tick();

    // Address errors.
    step(ld(32'h102, 5'd7, 2'b10, 1'b0), 1'b0, 1'b0);
    set_in('0, 1'b0, 1'b0);
    #1;
    chk("adel", {31'd0, adel}, 32'd1);
    chk("adel_en", {31'd0, data_sram_en}, 32'd0);
    tick();
    #1;
    chk("adel_no_rw", {31'd0, MEM_WB_RegWrite}, 32'd0);
    step(st(32'h101, 32'h55AA, 2'b01), 1'b0, 1'b0);
    set_in('0, 1'b0, 1'b0);
    #1;
    chk("ades", {31'd0, ades}, 32'd1);
    chk("ades_wen", {28'd0, data_sram_wen}, 32'd0);
    tick();

    // Stall while a load sits in WB; rdata is garbage throughout.
    step(ld(32'h100, 5'd9, 2'b10, 1'b0), 1'b0, 1'b0);
    step(alu(32'h55, 5'd10, 1'b0, 1'b0), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      set_in(alu(32'h99, 5'd11, 1'b0, 1'b0), 1'b1, 1'b0);
      #1;
      chk("stall_wb", WBvalue, 32'hDEAD_BEEF);
      chk("stall_em", EX_MEM_aluout, 32'h55);
      tick();
    end
    set_in('0, 1'b0, 1'b0);
    #1;
    chk("stall_release", WBvalue, 32'hDEAD_BEEF);
    tick();
    #1;
    chk("resume_wb", WBvalue, 32'h55);
    chk("resume_rd", {27'd0, MEM_WB_Rd}, 32'd10);

    // Bubbles, overflow, flush under stall.
    for (int k = 0; k < 5; k++) begin
      step(alu(32'h1234, 5'd12, 1'b0, 1'b1), 1'b0, 1'b0);
      chk("notok_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    end
    step(alu(32'h7FFF_FFFF, 5'd3, 1'b1, 1'b0), 1'b0, 1'b0);
    chk("ovf_rw", {31'd0, EX_MEM_RegWrite}, 32'd0);
    chk("ovf_result", EX_MEM_aluout, 32'h7FFF_FFFF);
    step(alu(32'h77, 5'd4, 1'b0, 1'b0), 1'b0, 1'b0);
    step(alu(32'h88, 5'd8, 1'b0, 1'b0), 1'b1, 1'b1);
    chk("flush_em_rd", {27'd0, EX_MEM_Rd}, 32'd0);
    chk("flush_wb_rd", {27'd0, MEM_WB_Rd}, 32'd3);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      step(rnd_ex(), ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
    end
    repeat (3) step('0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a load.
    step(ld(32'h100, 5'd13, 2'b10, 1'b0), 1'b0, 1'b0);
    step(ld(32'h180, 5'd14, 2'b10, 1'b0), 1'b0, 1'b0);
    set_in('0, 1'b0, 1'b0);
    #1;
    chk("pre_rst_en", {31'd0, data_sram_en}, 32'd1);
    chk_on = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_en", {31'd0, data_sram_en}, 32'd0);
    chk("mid_rst_addr", data_sram_addr, 32'd0);
    chk("mid_rst_wbvalue", WBvalue, 32'd0);
    chk("mid_rst_wb_rd", {27'd0, MEM_WB_Rd}, 32'd0);
    chk("mid_rst_em_mr", {31'd0, EX_MEM_MemRead}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Back-end pipeline block downstream of the execute stage. It holds the EX/MEM and MEM/WB pipeline registers and drives the data SRAM port from EX/MEM. It aligns and extends load data in WB and returns `EX_MEM_aluout` and `WBvalue` to the execute-stage forwarding muxes. It also detects data-address errors and suppresses register writes for faulting or overflowing instructions.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- ex_valid  in  1  execute stage holds a real instruction
- ex_out  in  32  execute result (ALU, HI/LO, PC+8); also the memory address
- ex_rt_data  in  32  forwarded Rt value (store data)
- ex_rd  in  5  destination register
- ex_regwrite, ex_memread, ex_memwrite, ex_mem_sign  in  1 each  control bits; ex_mem_sign=1 selects sign-extended loads
- ex_mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- ex_overflow, ex_result_notok  in  1 each  execute-stage status
- stall  in  1  freezes both pipeline registers
- flush  in  1  turns the EX/MEM load into a bubble
- data_sram_en  out  1  data SRAM enable
- data_sram_wen  out  4  byte write mask
- data_sram_addr, data_sram_wdata  out  32  address and replicated store data
- data_sram_rdata  in  32  read data, valid one cycle after en
- EX_MEM_aluout  out  32  forwarding source 1
- EX_MEM_Rd  out  5  EX/MEM destination register
- EX_MEM_RegWrite, EX_MEM_MemRead  out  1 each  EX/MEM control bits for hazard detection
- WBvalue  out  32  write-back data, also forwarding source 2
- MEM_WB_Rd  out  5  write-back destination register
- MEM_WB_RegWrite  out  1  register-file write enable
- adel, ades  out  1 each  load / store address error, combinational from EX/MEM

## Operation
- EX/MEM register loads on each edge unless stall=1.
  - Priority: flush, then stall, then ex_result_notok or ~ex_valid, then normal load.
  - flush loads a bubble even while stall=1.
  - ex_result_notok or ~ex_valid loads a bubble: valid=0 and all control bits 0.
  - A normal load captures the inputs. The stored regwrite is ex_regwrite & ~ex_overflow.
- Address error, evaluated only when EX/MEM is valid:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - adel = memread & misaligned. ades = memwrite & misaligned.
- data_sram_en = valid & (memread|memwrite) & ~adel & ~ades & ~stall.
- data_sram_addr = EX/MEM result.
- data_sram_wen is 0000 unless en & memwrite:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1],1'b0}
  - word: 1111
- data_sram_wdata:
  - byte: rt[7:0] replicated ×4
  - half: rt[15:0] replicated ×2
  - word: rt
- MEM/WB register loads on each edge unless stall=1.
  - It captures result, rd, memread, size, sign and addr[1:0].
  - regwrite = EX/MEM regwrite & ~adel.
  - It loads a bubble when EX/MEM is invalid.
- Load formatting in WB:
  - Source word is the hold register if hold_valid=1, else data_sram_rdata.
  - Select the byte or half by the stored addr[1:0], then sign- or zero-extend per the stored sign bit.
  - WBvalue = formatted data when memread=1, else the stored result.
- Read-data hold:
  - When stall=1, MEM/WB holds a load and hold_valid=0: capture data_sram_rdata and set hold_valid=1.
  - hold_valid clears on the edge where MEM/WB advances (stall=0).

## Timing
- Reset (rst=0, asynchronous): both registers become bubbles and hold_valid=0.
  - All outputs are 0: en, wen, addr, wdata, EX_MEM_*, MEM_WB_*, WBvalue, adel, ades.
- Latency:
  - EX inputs appear on the EX_MEM_* outputs one edge later.
  - They appear on MEM_WB_* and WBvalue two edges later.
  - Load data reaches WBvalue in the same cycle MEM_WB_Rd shows the load.
- Stall held for N cycles: both registers, en=0, wen=0, WBvalue stable.
  - The rdata hold guarantees stable load data even though the SRAM is not re-read.
- flush with stall: EX/MEM becomes a bubble and MEM/WB holds.
- ex_result_notok for k cycles inserts k bubbles. MEM/WB keeps draining unless stall=1.
- An address error never produces a register write. A store address error never asserts wen.

## Test plan
- Word store then load:
  - sw addr=0x100, rt=0xDEADBEEF gives wen=1111, wdata=0xDEADBEEF in the MEM cycle.
  - lw from 0x100 gives WBvalue=0xDEADBEEF and MEM_WB_RegWrite=1 two cycles after issue.
- Sub-word loads with rdata=0x8070_F0A5:
  - lb at addr[1:0]=0 gives 0xFFFFFFA5.
  - lbu at addr[1:0]=1 gives 0x000000F0.
  - lh at addr[1:0]=2 gives 0xFFFF8070.
- Stores:
  - sb rt=0x12 at addr[1:0]=3 gives wen=1000, wdata=0x12121212.
  - sh at offset 2 gives wen=1100.
- Address errors:
  - lw at 0x102 gives adel=1, en=0, and no register write.
  - sh at 0x101 gives ades=1, wen=0000.
- Stall during load WB: stall 3 cycles while the SRAM model drives garbage on rdata. WBvalue keeps the captured word, and registers resume unchanged.
- Bubbles and overflow:
  - ex_result_notok for 5 cycles gives 5 bubbles with RegWrite=0.
  - ex_overflow=1 add gives EX_MEM_RegWrite=0.
  - rst=0 mid-load clears all outputs immediately.
